// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} for HI/LO. While start_i is high and the
// result is not yet ready, it holds stallreq_o high. A flush cancels any
// operation that is in flight.
// Optional build macro DIV_EARLY_OUT_EN: when the dividend magnitude is
// below the divisor magnitude, the result is finished in one cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;     // partial remainder
    logic [WIDTH-1:0] dvd;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;     // divisor magnitude
    logic             neg_q;
    logic             neg_r;

    // Operand sign handling at acceptance
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero;
    logic             early;

    assign a_neg    = signed_i & dividend_i[WIDTH-1];
    assign b_neg    = signed_i & divisor_i[WIDTH-1];
    // abs(0x80..0) keeps the same bit pattern and is correct as an unsigned magnitude
    assign a_mag    = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign b_mag    = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero = (divisor_i == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // One restoring step: rem < dvs holds, so the shifted value fits in WIDTH+1 bits
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic             last;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign shifted = {rem, dvd[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign take    = ~diff[WIDTH];
    assign rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_nxt = {dvd[WIDTH-2:0], take};
    assign last    = (cnt == CW'(WIDTH - 1));
    assign q_fin   = neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
    assign r_fin   = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

    assign stallreq_o = start_i & ~ready_o;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FREE;
        else     state <= state_next;
    end

    // Next-state logic; flush overrides both acceptance and completion
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = FREE;
        end else begin
            case (state)
                FREE: begin
                    if (start_i) begin
                        if (div_zero)   state_next = BY_ZERO;
                        else if (early) state_next = END;
                        else            state_next = ON;
                    end
                end
                ON:      if (last) state_next = END;
                BY_ZERO: state_next = END;
                END:     if (!start_i) state_next = FREE;
                default: state_next = FREE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, and result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else if (flush) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i) begin
                        cnt   <= '0;
                        rem   <= '0;
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (!div_zero && early) begin
                            // |a| < |b|: quotient 0, remainder is the dividend itself
                            result_o <= {dividend_i, {WIDTH{1'b0}}};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                ON: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result_o <= {r_fin, q_fin};
                        ready_o  <= 1'b1;
                    end
                end
                BY_ZERO: begin
                    // Architecturally unpredictable; defined as zero here
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {HI,LO} and latency,
// a negedge monitor pops and compares on each rising ready_o.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

`ifdef DIV_EARLY_OUT_EN
    localparam int EL = 1;
`else
    localparam int EL = 33;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start_i(start_i),
        .signed_i(signed_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic rdy_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every new result is compared against the oldest expectation
    always @(negedge clk) begin
        if (ready_o && !rdy_prev) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=%h expected=no_result", result_o);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result_o, mon_e.res);
                chk("ready_cycle", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
        rdy_prev = ready_o;
    end

    // Full handshake: start held until ready, operands scrambled after acceptance
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] er, input int lat);
        int   n;
        int   stalls;
        exp_t e;
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = sg; dividend_i = a; divisor_i = b;
        e.res = er; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        n = 0; stalls = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            if (stallreq_o) stalls++;
            n++;
            if (n == 2) begin
                dividend_i = ~a; divisor_i = b + 32'd3; signed_i = ~sg;
            end
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL ready_timeout actual=none expected=cycle_%0d", lat);
                break;
            end
        end
        chk("stall_cycles", 64'(stalls), 64'(lat));
        chk("stallreq_at_ready", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        chk("hold_ready", {63'd0, ready_o}, 64'd1);
        chk("hold_result", result_o, er);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("ready_before_drop_edge", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        chk("ready_after_drop", {63'd0, ready_o}, 64'd0);
        chk("result_after_drop", result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        #10 rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_div(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33);
        run_div(1'b0, 32'h12345678, 32'h0, 64'd0, 2);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
        run_div(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 33);
        run_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, EL);
        run_div(1'b1, 32'hFFFFFFFD, 32'd8, {32'hFFFFFFFD, 32'd0}, EL);

        // Flush in cycle 10 of a divide, restart in cycle 12
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("flush_ready", {63'd0, ready_o}, 64'd0);
        chk("flush_result", result_o, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // start with flush in FREE is not accepted (divide-by-zero would show in cycle 2)
        @(posedge clk); #1;
        start_i = 1'b1; flush = 1'b1; dividend_i = 32'h12345678; divisor_i = 32'h0;
        @(posedge clk); #1;
        start_i = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_start_rejected", {63'd0, ready_o}, 64'd0);
        end

        // Async reset while a result is held
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        begin
            exp_t e;
            e.res = {32'd2, 32'd14}; e.lat = 33; e.t0 = cyc;
            sb.push_back(e);
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL ready_timeout_rst actual=none expected=cycle_33");
                break;
            end
        end
        #2 rst = 1'b1; start_i = 1'b0;
        #1;
        chk("async_rst_ready", {63'd0, ready_o}, 64'd0);
        chk("async_rst_result", result_o, 64'd0);
        #1 rst = 1'b0;

        // Async reset mid-divide, then a normal divide
        @(posedge clk); #1;
        start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1; start_i = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, ready_o}, 64'd0);
        chk("mid_rst_result", result_o, 64'd0);
        #1 rst = 1'b0;
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
